// File: rtl/pma_region_table.sv
// Runtime-programmable physical-memory-attribute table with per-slot lock and a
// single-register valid/ready lookup pipeline returning the lowest-index matching rule.
module pma_region_table #(
  parameter int unsigned NrRules     = 8,
  parameter int unsigned AddrWidth   = 64,
  parameter logic [2:0]  DefaultAttr = 3'b000,
  localparam int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [IdxW-1:0]      resp_idx_o,
  output logic [2:0]           resp_attr_o
);

  localparam logic [1:0] FieldBase = 2'd0;
  localparam logic [1:0] FieldLen  = 2'd1;
  localparam logic [1:0] FieldAttr = 2'd2;

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] base_d [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [AddrWidth-1:0] len_d  [NrRules];
  logic [2:0]           attr_q [NrRules];
  logic [2:0]           attr_d [NrRules];
  logic [NrRules-1:0]   lock_q, lock_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 slot_found;

  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_hit_q, resp_hit_d;
  logic [IdxW-1:0]      resp_idx_q, resp_idx_d;
  logic [2:0]           resp_attr_q, resp_attr_d;

  logic                 match_hit_c;
  logic [IdxW-1:0]      match_idx_c;
  logic [2:0]           match_attr_c;
  logic                 accept_c;

  // Parallel wrap-around range compare; descending scan so the lowest index wins.
  always_comb begin
    match_hit_c  = 1'b0;
    match_idx_c  = '0;
    match_attr_c = DefaultAttr;
    for (int i = int'(NrRules) - 1; i >= 0; i--) begin
      if ((len_q[i] != '0) && ((req_addr_i - base_q[i]) < len_q[i])) begin
        match_hit_c  = 1'b1;
        match_idx_c  = IdxW'(i);
        match_attr_c = attr_q[i];
      end
    end
  end

  // Config write decode; locked slots, the reserved field and absent slots reject.
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    attr_d     = attr_q;
    lock_d     = lock_q;
    cfg_err_d  = 1'b0;
    slot_found = 1'b0;
    if (cfg_we_i) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        if (cfg_idx_i == IdxW'(i)) begin
          slot_found = 1'b1;
          if (lock_q[i] || (cfg_field_i == 2'd3)) begin
            cfg_err_d = 1'b1;
          end else begin
            case (cfg_field_i)
              FieldBase: base_d[i] = cfg_wdata_i;
              FieldLen:  len_d[i]  = cfg_wdata_i;
              FieldAttr: begin
                attr_d[i] = cfg_wdata_i[2:0];
                lock_d[i] = cfg_wdata_i[3];
              end
              default: ;
            endcase
          end
        end
      end
      if (!slot_found) cfg_err_d = 1'b1;
    end
  end

  assign req_ready_o = !resp_valid_q || resp_ready_i;
  assign accept_c    = req_valid_i && req_ready_o;

  // Output stage: load on accept, drop on consume, otherwise hold.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_idx_d   = resp_idx_q;
    resp_attr_d  = resp_attr_q;
    if (accept_c) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = match_hit_c;
      resp_idx_d   = match_idx_c;
      resp_attr_d  = match_attr_c;
    end else if (resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        attr_q[i] <= '0;
      end
      lock_q       <= '0;
      cfg_err_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= '0;
      resp_attr_q  <= DefaultAttr;
    end else begin
      base_q       <= base_d;
      len_q        <= len_d;
      attr_q       <= attr_d;
      lock_q       <= lock_d;
      cfg_err_q    <= cfg_err_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_idx_q   <= resp_idx_d;
      resp_attr_q  <= resp_attr_d;
    end
  end

  assign cfg_err_o    = cfg_err_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_idx_o   = resp_idx_q;
  assign resp_attr_o  = resp_attr_q;

endmodule

// File: tb/tb_pma_region_table.sv
// Bench for pma_region_table: directed vector table, hand sequences for stall,
// lock, same-edge and reset cases, then random traffic against a span-based model.
module tb_pma_region_table;

  localparam logic [2:0] DEF = 3'b001;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [1:0]  cfg_field = '0;
  logic [63:0] cfg_wdata = '0;
  logic        cfg_err;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_hit;
  logic [2:0]  resp_idx;
  logic [2:0]  resp_attr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pma_region_table #(.NrRules(8), .AddrWidth(64), .DefaultAttr(DEF)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_err_o(cfg_err),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_hit_o(resp_hit), .resp_idx_o(resp_idx), .resp_attr_o(resp_attr)
  );

  // Reference model: rule table plus the expected output-register contents.
  logic [63:0] m_base [8];
  logic [63:0] m_len  [8];
  logic [2:0]  m_attr [8];
  logic        m_lock [8];
  logic        e_valid, e_hit, e_err;
  logic [2:0]  e_idx, e_attr;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_base[i] = '0; m_len[i] = '0; m_attr[i] = '0; m_lock[i] = 1'b0;
    end
    e_valid = 1'b0; e_hit = 1'b0; e_idx = '0; e_attr = DEF; e_err = 1'b0;
  endfunction

  // Span [base, base+len) in 65-bit arithmetic; a carry out means the span wraps.
  function automatic void model_lookup(input logic [63:0] a, output logic h,
                                       output logic [2:0] ix, output logic [2:0] at);
    logic [64:0] span_end;
    logic        m;
    h = 1'b0; ix = '0; at = DEF;
    for (int i = 0; i < 8; i++) begin
      span_end = {1'b0, m_base[i]} + {1'b0, m_len[i]};
      if (m_len[i] == 64'd0)    m = 1'b0;
      else if (!span_end[64])   m = (a >= m_base[i]) && (a < span_end[63:0]);
      else                      m = (a >= m_base[i]) || (a < span_end[63:0]);
      if (m && !h) begin
        h = 1'b1; ix = 3'(i); at = m_attr[i];
      end
    end
  endfunction

  function automatic logic model_write(input logic [2:0] ix, input logic [1:0] f, input logic [63:0] d);
    if (f == 2'd3 || m_lock[ix]) return 1'b1;
    case (f)
      2'd0: m_base[ix] = d;
      2'd1: m_len[ix]  = d;
      default: begin m_attr[ix] = d[2:0]; m_lock[ix] = d[3]; end
    endcase
    return 1'b0;
  endfunction

  // One clock: drive at negedge, advance the model, compare after the rising edge.
  task automatic step(input logic we, input logic [2:0] ix, input logic [1:0] f,
                      input logic [63:0] d, input logic rv, input logic [63:0] a,
                      input logic rr);
    logic acc, h;
    logic [2:0] mi, ma;
    @(negedge clk);
    cfg_we = we; cfg_idx = ix; cfg_field = f; cfg_wdata = d;
    req_valid = rv; req_addr = a; resp_ready = rr;
    #1;
    check("req_ready", 64'(req_ready), 64'(!e_valid || rr));
    acc = rv && (!e_valid || rr);
    if (acc) begin
      model_lookup(a, h, mi, ma);
      e_valid = 1'b1; e_hit = h; e_idx = mi; e_attr = ma;
    end else if (rr) begin
      e_valid = 1'b0;
    end
    e_err = we ? model_write(ix, f, d) : 1'b0;
    @(posedge clk);
    #1;
    check("resp_valid", 64'(resp_valid), 64'(e_valid));
    check("cfg_err", 64'(cfg_err), 64'(e_err));
    if (e_valid) begin
      check("resp_hit", 64'(resp_hit), 64'(e_hit));
      check("resp_idx", 64'(resp_idx), 64'(e_idx));
      check("resp_attr", 64'(resp_attr), 64'(e_attr));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    cfg_we = 1'b0; req_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_hit", 64'(resp_hit), 64'd0);
    check("rst_idx", 64'(resp_idx), 64'd0);
    check("rst_attr", 64'(resp_attr), 64'(DEF));
    check("rst_err", 64'(cfg_err), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [1:0]  field;
    logic [63:0] data;
    logic        rv;
    logic [63:0] addr;
    logic        xerr;
    logic        xhit;
    logic [2:0]  xidx;
    logic [2:0]  xattr;
  } vec_t;

  vec_t vecs [22];

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 2'd0, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[1]  = '{1'b1, 3'd0, 2'd1, 64'h4000_0000, 1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[2]  = '{1'b1, 3'd0, 2'd2, 64'h3,         1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[3]  = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h8000_1000, 1'b0, 1'b1, 3'd0, 3'b011};
    vecs[4]  = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h7FFF_FFFF, 1'b0, 1'b0, 3'd0, DEF};
    vecs[5]  = '{1'b1, 3'd1, 2'd0, 64'h1_0000,  1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[6]  = '{1'b1, 3'd1, 2'd1, 64'h1_0000,  1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[7]  = '{1'b1, 3'd1, 2'd2, 64'h4,       1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[8]  = '{1'b1, 3'd3, 2'd0, 64'h0,       1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[9]  = '{1'b1, 3'd3, 2'd1, 64'h10_0000, 1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[10] = '{1'b1, 3'd3, 2'd2, 64'h2,       1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[11] = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h1_8000, 1'b0, 1'b1, 3'd1, 3'b100};
    vecs[12] = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h2_0000, 1'b0, 1'b1, 3'd3, 3'b010};
    vecs[13] = '{1'b1, 3'd5, 2'd3, 64'h1234, 1'b0, 64'h0, 1'b1, 1'b0, 3'd0, 3'd0};
    vecs[14] = '{1'b1, 3'd2, 2'd2, 64'hB,    1'b0, 64'h0, 1'b0, 1'b0, 3'd0, 3'd0};
    vecs[15] = '{1'b1, 3'd2, 2'd1, 64'h100,  1'b0, 64'h0, 1'b1, 1'b0, 3'd0, 3'd0};
    vecs[16] = '{1'b1, 3'd2, 2'd0, 64'h40,   1'b0, 64'h0, 1'b1, 1'b0, 3'd0, 3'd0};
    vecs[17] = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h50,        1'b0, 1'b1, 3'd3, 3'b010};
    vecs[18] = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'hC000_0000, 1'b0, 1'b0, 3'd0, DEF};
    vecs[19] = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'hBFFF_FFFF, 1'b0, 1'b1, 3'd0, 3'b011};
    vecs[20] = '{1'b1, 3'd1, 2'd1, 64'h0, 1'b1, 64'h1_8000, 1'b0, 1'b1, 3'd1, 3'b100};
    vecs[21] = '{1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h1_8000, 1'b0, 1'b1, 3'd3, 3'b010};

    model_reset();
    do_reset();

    foreach (vecs[k]) begin
      step(vecs[k].we, vecs[k].idx, vecs[k].field, vecs[k].data, vecs[k].rv, vecs[k].addr, 1'b1);
      check($sformatf("vec%0d_err", k), 64'(cfg_err), 64'(vecs[k].xerr));
      if (vecs[k].rv) begin
        check($sformatf("vec%0d_hit", k), 64'(resp_hit), 64'(vecs[k].xhit));
        check($sformatf("vec%0d_idx", k), 64'(resp_idx), 64'(vecs[k].xidx));
        check($sformatf("vec%0d_attr", k), 64'(resp_attr), 64'(vecs[k].xattr));
      end
    end

    // Lock clears only on reset: rule2 accepts writes again afterwards.
    do_reset();
    step(1'b1, 3'd2, 2'd1, 64'h100, 1'b0, 64'h0, 1'b1);
    check("unlock_err", 64'(cfg_err), 64'd0);
    step(1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h50, 1'b1);
    check("unlock_idx", 64'(resp_idx), 64'd2);
    check("unlock_hit", 64'(resp_hit), 64'd1);

    // Backpressure: first result held for 3 stalled cycles despite a rule rewrite.
    do_reset();
    step(1'b1, 3'd0, 2'd0, 64'h1000, 1'b0, 64'h0, 1'b1);
    step(1'b1, 3'd0, 2'd1, 64'h1000, 1'b0, 64'h0, 1'b1);
    step(1'b1, 3'd0, 2'd2, 64'h1,    1'b0, 64'h0, 1'b1);
    step(1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h1800, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(c == 1, 3'd0, 2'd2, 64'h6, 1'b1, 64'h5000, 1'b0);
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_attr", 64'(resp_attr), 64'h1);
      check("stall_hit", 64'(resp_hit), 64'd1);
    end
    step(1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h5000, 1'b1);
    check("release_valid", 64'(resp_valid), 64'd1);
    check("release_hit", 64'(resp_hit), 64'd0);
    check("release_attr", 64'(resp_attr), 64'(DEF));
    step(1'b0, 3'd0, 2'd0, 64'h0, 1'b0, 64'h0, 1'b1);
    check("drain_valid", 64'(resp_valid), 64'd0);

    // Same-edge write and lookup: the lookup sees the pre-write table.
    do_reset();
    step(1'b1, 3'd0, 2'd0, 64'h8000_0000, 1'b0, 64'h0, 1'b1);
    step(1'b1, 3'd0, 2'd1, 64'h100,       1'b0, 64'h0, 1'b1);
    step(1'b1, 3'd0, 2'd1, 64'h0, 1'b1, 64'h8000_0000, 1'b1);
    check("same_edge_hit", 64'(resp_hit), 64'd1);
    step(1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h8000_0000, 1'b1);
    check("after_edge_hit", 64'(resp_hit), 64'd0);

    // Wrap past 2^64, then reset with a response pending.
    step(1'b1, 3'd0, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 64'h0, 1'b1);
    step(1'b1, 3'd0, 2'd1, 64'h2000, 1'b0, 64'h0, 1'b1);
    step(1'b1, 3'd0, 2'd2, 64'h5,    1'b0, 64'h0, 1'b1);
    step(1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h800, 1'b0);
    check("wrap_hit", 64'(resp_hit), 64'd1);
    check("wrap_attr", 64'(resp_attr), 64'h5);
    check("wrap_pending", 64'(resp_valid), 64'd1);
    do_reset();
    step(1'b0, 3'd0, 2'd0, 64'h0, 1'b1, 64'h800, 1'b1);
    check("wrap_after_rst", 64'(resp_hit), 64'd0);

    // Random traffic against the model, with periodic resets to clear locks.
    for (int n = 0; n < 600; n++) begin
      logic [63:0] d;
      logic [1:0]  f;
      if (n % 150 == 149) do_reset();
      f = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case (f)
        2'd0:    d = 64'($urandom_range(0, 32'h1_FFFF));
        2'd1:    d = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(1, 32'h8000));
        default: d = 64'($urandom_range(0, 7)) | (($urandom_range(0, 19) == 0) ? 64'h8 : 64'h0)
                     | 64'($urandom_range(0, 3) << 4);
      endcase
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), f, d,
           $urandom_range(0, 9) < 7, 64'($urandom_range(0, 32'h2_FFFF)),
           $urandom_range(0, 9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pma_region_table.md
# pma_region_table

Runtime-programmable physical-memory-attribute table that replaces fixed elaboration-time region rules (non-idempotent, executable, cached) with a register-backed rule set. Any number of rules up to `NrRules` can be written at run time by a configuration port, and individual rules can be locked until reset. Address lookups go through a one-stage pipelined valid/ready interface that returns the attributes of the highest-priority matching rule. The block sits beside the MMU/PMP path and feeds the cache and load/store units.

## Interface
- `NrRules`, default 8: number of rule slots; legal range 1..16.
- `AddrWidth`, default 64: physical address width; also the base and length field width.
- `DefaultAttr`, default 3'b000: attribute bits `{nonidem, exec, cached}` returned when no rule hits.
- `IdxW`, derived: max(1, $clog2(NrRules)).
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: asynchronous active-low reset.
- `cfg_we_i` in, 1: configuration write strobe.
- `cfg_idx_i` in, IdxW: target rule slot.
- `cfg_field_i` in, 2: field select. 0 = base, 1 = length, 2 = attr, 3 = reserved.
- `cfg_wdata_i` in, AddrWidth: write data. For attr, bits[2:0] = `{nonidem, exec, cached}` and bit[3] = lock.
- `cfg_err_o` out, 1: one-cycle pulse on a rejected write.
- `req_valid_i` in, 1: lookup request valid.
- `req_ready_o` out, 1: lookup request accepted.
- `req_addr_i` in, AddrWidth: lookup address.
- `resp_valid_o` out, 1: response valid.
- `resp_ready_i` in, 1: response consumed.
- `resp_hit_o` out, 1: a rule matched.
- `resp_idx_o` out, IdxW: index of the matching rule; 0 when there is no hit.
- `resp_attr_o` out, 3: `{nonidem, exec, cached}` of the matching rule, or `DefaultAttr` on a miss.

## Operation
- **Rule storage.** Each slot holds `base` (AddrWidth), `length` (AddrWidth), `attr` (3 bits) and `lock` (1 bit).
- **Match condition.** A slot matches when `length != 0` and `(req_addr_i - base)` mod 2^AddrWidth `< length`, compared unsigned.
  - The span is [base, base+length).
  - A span that crosses 2^AddrWidth wraps to address 0; this is intended.
  - `length == 0` disables the slot.
- **Priority.** When several slots match, the lowest index wins.
- **Config writes.** Applied on the clock edge where `cfg_we_i` = 1.
  - Writes to a slot with `lock` = 1 are dropped.
  - Writes to `cfg_field_i` = 3 are dropped.
  - Writes with `cfg_idx_i >= NrRules` are dropped.
  - Each dropped write raises `cfg_err_o` for the next cycle.
  - Writing the attr field with bit[3] = 1 sets `lock`. `lock` is sticky and cleared only by reset.
  - Unused `cfg_wdata_i` bits in an attr write are ignored.
- **Lookup pipeline.** A single output register stage.
  - A request is accepted when `req_valid_i && req_ready_o`.
  - `req_ready_o = !resp_valid_o || resp_ready_i`, with no combinational path from `req_valid_i`.
  - On acceptance, match, priority and attr are computed from the table contents before that edge's config write, then registered.
  - `resp_valid_o` clears when `resp_ready_i` = 1 and no new request is accepted.
  - While `resp_valid_o && !resp_ready_i`, all `resp_*` outputs hold stable, even if the table is rewritten.
- **Reset.** All slots return to base 0, length 0, attr 0, lock 0.
  - `resp_valid_o` = 0, `resp_hit_o` = 0, `resp_idx_o` = 0, `resp_attr_o` = `DefaultAttr`.
  - `cfg_err_o` = 0; `req_ready_o` = 1.
  - Reset asserted mid-transaction discards the pending response.

## Timing
- **Lookup latency.** Request accepted at edge N; response visible after edge N, i.e. in cycle N+1.
- **Throughput.** One lookup per cycle when `resp_ready_i` = 1.
- **Config write visibility.** A write at edge N is seen by requests accepted at edge N+1 or later; a request accepted at edge N sees the old value.
- **Error pulse.** `cfg_err_o` is high for exactly the one cycle after the rejected write edge.
- **Critical path.** NrRules parallel AddrWidth-bit subtract/compares followed by a priority encoder, all within one cycle. No additional stages.

## Test plan
- **Basic hit/miss.** Program rule0 base=0x8000_0000, len=0x4000_0000, attr=3'b011. Lookup 0x8000_1000 → next cycle hit=1, idx=0, attr=011. Lookup 0x7FFF_FFFF → hit=0, attr=DefaultAttr.
- **Priority.** rule1 covers 0x1_0000 + 0x1_0000 with attr=100; rule3 covers 0x0 + 0x10_0000 with attr=010. Lookup 0x1_8000 → idx=1, attr=100. Lookup 0x2_0000 → idx=3, attr=010.
- **Lock.** Write rule2 attr with data 0xB (lock + attr 011). Then write rule2 length=0x100 → `cfg_err_o` pulses one cycle and rule2 length is unchanged. Assert and release `rst_ni`, rewrite rule2 → accepted.
- **Backpressure.** Issue back-to-back lookups with `resp_ready_i` = 0 for 3 cycles. `resp_*` holds the first result and `req_ready_o` = 0. Rewrite rule0 during the stall → held response unchanged. Release → the second request completes the next cycle.
- **Same-edge write and lookup.** Write rule0 length=0 on the same edge a lookup of 0x8000_0000 is accepted → response hit=1. The next lookup → hit=0.
- **Wrap and reset.** Rule0 base=0xFFFF_FFFF_FFFF_F000, len=0x2000. Lookup 0x800 → hit. Assert reset while `resp_valid_o` = 1 → `resp_valid_o` = 0 immediately; after release, lookup 0x800 → miss.
